instr_rom: RTL and testbench
============================

// Module: instr_rom
// PURPOSE
//   Read-only instruction memory for the single-cycle CPU fetch unit.
//   32 words x 32 bits, word-addressed: the fetch unit drives byte PC[6:2].
//   Primary read path is combinational, so the instruction is valid in the
//   same cycle as the PC. A registered copy of the read word is provided
//   for pipelined or debug consumers.
// PARAMETERS
//   AW  5   address width in words (depth = 2**AW = 32)
//   DW  32  data/instruction width in bits
//   Contents are fixed for AW=5, DW=32; other values are unsupported.
// PORTS
//   clock   in   1   system clock, rising-edge
//   reset   in   1   asynchronous, active-high reset
//   addr    in   5   word address (byte PC[6:2])
//   data    out  32  instruction at addr, combinational
//   data_q  out  32  data registered on the clock edge
// BEHAVIOUR
//   - data = MEM[addr], purely combinational, with zero latency.
//     Unaffected by clock and reset.
//   - data_q:
//     * reset=1 (asynchronous): data_q = 0 immediately, held while reset is high.
//     * Otherwise, on each posedge clock: data_q <= MEM[addr].
//     * Latency is 1 cycle.
//   - No write port. Contents are constant and fixed in RTL (case table):
//     w0  8C010000 lw  $1,0($0)     w1  8C020004 lw  $2,4($0)
//     w2  00221820 add $3,$1,$2     w3  00222022 sub $4,$1,$2
//     w4  00222824 and $5,$1,$2     w5  00223025 or  $6,$1,$2
//     w6  0022382A slt $7,$1,$2     w7  AC030008 sw  $3,8($0)
//     w8  10210001 beq $1,$1,+1     w9  00000000 nop (skipped)
//     w10 08000001 j   +1 (PC-relative: next_pc + imm<<2 -> w12)
//     w11 00000000 nop (skipped)    w12 03E00008 jr  $31
//     w13..w31 00000000
//   - Every 5-bit address is valid; there is no out-of-range case.
//     Unlisted words read as 0.
//   - Address changes propagate to data in the same cycle with no glitch
//     requirement. X or Z on addr gives X on data.
//   - Reset is deasserted asynchronously. The first capture happens on the
//     first posedge after deassertion.
// TESTING
//   1. Assert reset, sweep clock -> data_q=0 throughout; data still tracks addr.
//   2. addr=0 -> data=8C010000. addr=2 -> data=00221820 in the same delta,
//      with no clock.
//   3. addr=8, posedge clock -> data_q=10210001. Change addr=12 before the
//      edge -> data=03E00008 while data_q holds until the next edge.
//   4. Sweep addr 0..31 -> match the table; w13..w31 read 00000000.
//   5. Pulse reset mid-cycle with data_q=08000001 -> data_q=0 before the next
//      edge; data unchanged.
//   6. Release reset with addr=7 -> data_q=AC030008 after the first posedge.

Source files
------------

// File: rtl/instr_rom.sv
`default_nettype none
// ============================================================================
// Module   : instr_rom
// Purpose  : Read-only instruction memory for the single-cycle CPU fetch
//            unit. 32 words x 32 bits, word addressed (byte PC[6:2]).
//            Combinational read path plus a registered copy of the word.
// Ports    : clock   in   1   system clock, rising edge
//            reset   in   1   asynchronous, active-high reset
//            addr    in   AW  word address
//            data    out  DW  instruction at addr, combinational
//            data_q  out  DW  data captured on the rising clock edge
// Revision : 1.0  initial release
// ============================================================================
module instr_rom #(
  parameter int AW = 5,
  parameter int DW = 32
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [AW-1:0] addr,
  output logic [DW-1:0] data,
  output logic [DW-1:0] data_q
);

  localparam int DEPTH = 2 ** AW;

  // Fixed program image. Words not listed read as zero.
  function automatic logic [DW-1:0] rom_word(input int idx);
    logic [DW-1:0] w;
    w = '0;
    case (idx)
      0:  w = 32'h8C01_0000; // lw  $1,0($0)
      1:  w = 32'h8C02_0004; // lw  $2,4($0)
      2:  w = 32'h0022_1820; // add $3,$1,$2
      3:  w = 32'h0022_2022; // sub $4,$1,$2
      4:  w = 32'h0022_2824; // and $5,$1,$2
      5:  w = 32'h0022_3025; // or  $6,$1,$2
      6:  w = 32'h0022_382A; // slt $7,$1,$2
      7:  w = 32'hAC03_0008; // sw  $3,8($0)
      8:  w = 32'h1021_0001; // beq $1,$1,+1
      9:  w = 32'h0000_0000; // nop (skipped)
      10: w = 32'h0800_0001; // j   +1 -> w12
      11: w = 32'h0000_0000; // nop (skipped)
      12: w = 32'h03E0_0008; // jr  $31
      default: w = '0;
    endcase
    return w;
  endfunction

  // The table is expanded into a constant array and read by indexing, so an
  // unknown address yields an unknown word in 4-state simulation instead of
  // silently aliasing to the default entry.
  logic [DW-1:0] rom [DEPTH];

  for (genvar i = 0; i < DEPTH; i++) begin : g_rom
    assign rom[i] = rom_word(i);
  end

  assign data = rom[addr];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      data_q <= '0;
    end else begin
      data_q <= data;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_instr_rom.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_rom
// Purpose  : Self-checking bench for instr_rom. Stimulus pushes expected
//            values into a scoreboard queue; a monitor pops and compares.
// Revision : 1.0  initial release
// ============================================================================
module tb_instr_rom;

  logic        clock;
  logic        reset;
  logic [4:0]  addr;
  logic [31:0] data;
  logic [31:0] data_q;

  instr_rom #(.AW(5), .DW(32)) dut (
    .clock  (clock),
    .reset  (reset),
    .addr   (addr),
    .data   (data),
    .data_q (data_q)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    string       name;
    bit          is_q;
    logic [31:0] exp;
  } sb_item_t;

  sb_item_t    sb_q[$];
  event        sample_ev;
  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_mem [32];
  bit          done = 1'b0;

  // Monitor: on every sample request, drain the queue against live outputs.
  initial begin
    forever begin
      @(sample_ev);
      while (sb_q.size() > 0) begin
        sb_item_t it;
        logic [31:0] act;
        it  = sb_q.pop_front();
        act = it.is_q ? data_q : data;
        checks++;
        if (act !== it.exp) begin
          errors++;
          $display("FAIL %s: got %08h expected %08h", it.name, act, it.exp);
        end
      end
    end
  end

  task automatic expect_out(input string name, input bit is_q, input logic [31:0] exp);
    sb_item_t it;
    it.name = name;
    it.is_q = is_q;
    it.exp  = exp;
    sb_q.push_back(it);
  endtask

  task automatic sample();
    -> sample_ev;
    #0;
  endtask

  task automatic after_posedge();
    @(posedge clock);
    #1;
  endtask

  // Hand-written program image.
  initial begin
    for (int i = 0; i < 32; i++) exp_mem[i] = 32'h0;
    exp_mem[0]  = 32'h8C010000; exp_mem[1]  = 32'h8C020004;
    exp_mem[2]  = 32'h00221820; exp_mem[3]  = 32'h00222022;
    exp_mem[4]  = 32'h00222824; exp_mem[5]  = 32'h00223025;
    exp_mem[6]  = 32'h0022382A; exp_mem[7]  = 32'hAC030008;
    exp_mem[8]  = 32'h10210001; exp_mem[10] = 32'h08000001;
    exp_mem[12] = 32'h03E00008;
  end

  // Watchdog: the run must always end on its own.
  initial begin
    #100000;
    if (!done) begin
      errors++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
    end
  end

  initial begin
    reset = 1'b1;
    addr  = 5'd0;
    #1;
    expect_out("reset_data_q", 1'b1, 32'h0);
    sample();

    // Reset held across several edges: data_q stays 0, data still tracks addr.
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      addr = 5'(k * 3);
      #1;
      expect_out("reset_data_track", 1'b0, exp_mem[k * 3]);
      sample();
      after_posedge();
      expect_out("reset_hold_q", 1'b1, 32'h0);
      sample();
    end

    // Asynchronous release mid-cycle; combinational reads without an edge.
    @(negedge clock);
    reset = 1'b0;
    addr  = 5'd0;
    #1;
    expect_out("comb_w0", 1'b0, 32'h8C010000);
    expect_out("q_after_release", 1'b1, 32'h0);
    sample();
    addr = 5'd2;
    #1;
    expect_out("comb_w2", 1'b0, 32'h00221820);
    sample();

    // Registered path latency and hold behaviour.
    @(negedge clock);
    addr = 5'd8;
    after_posedge();
    expect_out("q_w8", 1'b1, 32'h10210001);
    sample();
    addr = 5'd12;
    #1;
    expect_out("comb_w12", 1'b0, 32'h03E00008);
    expect_out("q_hold_w8", 1'b1, 32'h10210001);
    sample();
    after_posedge();
    expect_out("q_w12", 1'b1, 32'h03E00008);
    sample();

    // Full address sweep on both outputs.
    for (int i = 0; i < 32; i++) begin
      @(negedge clock);
      addr = 5'(i);
      #1;
      expect_out($sformatf("sweep_data_%0d", i), 1'b0, exp_mem[i]);
      sample();
      after_posedge();
      expect_out($sformatf("sweep_q_%0d", i), 1'b1, exp_mem[i]);
      sample();
    end

    // Mid-cycle reset pulse clears data_q without waiting for an edge.
    @(negedge clock);
    addr = 5'd10;
    after_posedge();
    expect_out("q_w10", 1'b1, 32'h08000001);
    sample();
    #2;
    reset = 1'b1;
    #1;
    expect_out("async_clear_q", 1'b1, 32'h0);
    expect_out("async_data_kept", 1'b0, 32'h08000001);
    sample();

    // Release with addr=7: first capture on the first edge after release.
    addr = 5'd7;
    #1;
    reset = 1'b0;
    #1;
    expect_out("q_before_first_edge", 1'b1, 32'h0);
    sample();
    after_posedge();
    expect_out("q_first_capture_w7", 1'b1, 32'hAC030008);
    sample();

    #1;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
    end
    done = 1'b1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
